// File: rtl/rgb_arbiter.sv
// Fixed-priority LED arbiter: one requester at a time owns the RGB drive,
// with a tick-counted minimum dwell after each grant and optional blinking.
module rgb_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_TICKS  = 8,
    parameter int BLINK_TICKS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] color,
    input  logic [NREQ-1:0]   blink,
    output logic              r,
    output logic              g,
    output logic              b,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;

    state_t          state, state_nx;
    logic [HW-1:0]   hold_cnt, hold_nx;
    logic [BW-1:0]   blink_cnt, blink_nx;
    logic            phase, phase_nx;
    logic [2:0]      lat_col, col_nx;
    logic            lat_blk, blk_nx;
    logic [2:0]      rgb_q, rgb_nx;
    logic [NREQ-1:0] grant_nx;
    logic            busy_nx;

    logic [NREQ-1:0] lowest, higher, higher_low, sel;
    logic            owner_req, do_grant;

    // Two's-complement trick isolates the lowest set bit; grant-1 masks the
    // indices strictly above the one-hot owner in priority.
    assign lowest     = req & (~req + NREQ'(1));
    assign higher     = req & (grant - NREQ'(1));
    assign higher_low = higher & (~higher + NREQ'(1));
    assign owner_req  = |(req & grant);

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        blink_nx = blink_cnt;
        phase_nx = phase;
        col_nx   = lat_col;
        blk_nx   = lat_blk;
        grant_nx = grant;
        do_grant = 1'b0;
        sel      = '0;

        case (state)
            IDLE: begin
                if (|req) begin
                    do_grant = 1'b1;
                    sel      = lowest;
                end
            end
            HOLD: begin
                if (tick && hold_cnt != '0) begin
                    hold_nx = hold_cnt - HW'(1);
                    if (hold_cnt == HW'(1))
                        state_nx = RUN;
                end
            end
            RUN: begin
                if (|higher) begin
                    do_grant = 1'b1;
                    sel      = higher_low;
                end else if (!owner_req) begin
                    if (|req) begin
                        do_grant = 1'b1;
                        sel      = lowest;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state != IDLE && lat_blk && tick && blink_cnt != '0) begin
            if (blink_cnt == BW'(1)) begin
                phase_nx = ~phase;
                blink_nx = BW'(BLINK_TICKS);
            end else begin
                blink_nx = blink_cnt - BW'(1);
            end
        end

        // A grant reloads everything, so a coincident tick is discarded here.
        if (do_grant) begin
            state_nx = HOLD;
            grant_nx = sel;
            hold_nx  = HW'(HOLD_TICKS);
            blink_nx = BW'(BLINK_TICKS);
            phase_nx = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (sel[i]) begin
                    col_nx = color[3*i +: 3];
                    blk_nx = blink[i];
                end
            end
        end

        if (state_nx == IDLE)
            grant_nx = '0;
        busy_nx = (state_nx != IDLE);
        rgb_nx  = (state_nx == IDLE) ? 3'b000 : (col_nx & {3{phase_nx | ~blk_nx}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            lat_col   <= 3'b000;
            lat_blk   <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            rgb_q     <= 3'b000;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            blink_cnt <= blink_nx;
            phase     <= phase_nx;
            lat_col   <= col_nx;
            lat_blk   <= blk_nx;
            grant     <= grant_nx;
            busy      <= busy_nx;
            rgb_q     <= rgb_nx;
        end
    end

    assign {r, g, b} = rgb_q;

endmodule

// File: tb/tb_rgb_arbiter.sv
// Bench for rgb_arbiter: directed scenarios plus randomized traffic against
// an owner/dwell/blink reference model.
module tb_rgb_arbiter;
    localparam int N  = 4;
    localparam int HT = 2;
    localparam int BT = 3;

    logic         clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
    logic [N-1:0] req = '0, blink = '0;
    logic [3*N-1:0] color = '0;
    logic         r, g, b, busy;
    logic [N-1:0] grant;

    int checks = 0, errors = 0;

    // reference model: owner index (-1 idle), ticks left in dwell, blink state
    int         m_owner, m_hold, m_bcnt;
    bit         m_on, m_blk;
    logic [2:0] m_col;

    rgb_arbiter #(.NREQ(N), .HOLD_TICKS(HT), .BLINK_TICKS(BT)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .color(color),
        .blink(blink), .r(r), .g(g), .b(b), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    function automatic int lowest_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_hold = 0; m_bcnt = 0; m_on = 1; m_col = 3'b000; m_blk = 0;
    endtask

    task automatic model_step();
        int  j;
        bit  granted, was_busy;
        j = lowest_idx(req);
        granted = 0;
        was_busy = (m_owner >= 0);
        if (m_owner < 0) begin
            if (j >= 0) begin m_owner = j; granted = 1; end
        end else if (m_hold > 0) begin
            if (tick) m_hold--;
        end else if (j < 0) begin
            m_owner = -1;
        end else if (j != m_owner) begin
            m_owner = j; granted = 1;
        end
        if (granted) begin
            m_hold = HT; m_bcnt = BT; m_on = 1;
            m_col = color[3*m_owner +: 3];
            m_blk = blink[m_owner];
        end else if (was_busy && m_owner >= 0 && m_blk && tick) begin
            m_bcnt--;
            if (m_bcnt == 0) begin m_on = !m_on; m_bcnt = BT; end
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] one;
        one = 1;
        return (m_owner < 0) ? '0 : (one << m_owner);
    endfunction

    function automatic logic [2:0] exp_rgb();
        if (m_owner < 0) return 3'b000;
        return (m_on || !m_blk) ? m_col : 3'b000;
    endfunction

    task automatic drive(input logic [N-1:0] rq, input logic tk);
        @(negedge clk);
        req = rq; tick = tk;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0; tick = 0; rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({r, g, b} !== 3'b000) begin errors++; $display("FAIL reset_rgb got %b want 000", {r, g, b}); end
        color[2:0] = 3'b110;
        req = 4'b0001; rst_n = 1;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL release_early got %b want 0000", grant); end
        @(posedge clk);
        model_step();
        #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL release_first_grant got %b want 0001", grant); end
        checks++; if ({r, g, b} !== 3'b110) begin errors++; $display("FAIL release_rgb got %b want 110", {r, g, b}); end
    endtask

    task automatic test_basic();
        do_reset();
        color = '0; blink = '0; color[8:6] = 3'b101;
        drive(4'b0000, 1);
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL idle_stays got busy=%b grant=%b want 0 0000", busy, grant); end
        drive(4'b0100, 0);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL basic_grant got %b want 0100", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        checks++; if ({r, g, b} !== 3'b101) begin errors++; $display("FAIL basic_rgb got %b want 101", {r, g, b}); end
        drive(4'b0100, 1);
        drive(4'b0100, 1);
        drive(4'b0101, 0);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL basic_run_after_2 got %b want 0001", grant); end
    endtask

    task automatic test_hold_ignore();
        do_reset();
        color = '0; blink = '0; color[8:6] = 3'b101; color[2:0] = 3'b011;
        drive(4'b0100, 0);
        drive(4'b0101, 0);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL hold_hp_ignored got %b want 0100", grant); end
        drive(4'b0101, 1);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL hold_after_tick1 got %b want 0100", grant); end
        drive(4'b0001, 0);
        checks++; if (grant !== 4'b0100 || {r, g, b} !== 3'b101) begin errors++; $display("FAIL hold_owner_drop got %b/%b want 0100/101", grant, {r, g, b}); end
        drive(4'b0101, 1);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL hold_tick2 got %b want 0100", grant); end
        drive(4'b0101, 0);
        checks++; if (grant !== 4'b0001 || {r, g, b} !== 3'b011) begin errors++; $display("FAIL run_preempt got %b/%b want 0001/011", grant, {r, g, b}); end
    endtask

    task automatic test_release();
        do_reset();
        color = '0; blink = '0; color[5:3] = 3'b111;
        drive(4'b0010, 0);
        drive(4'b0010, 1);
        drive(4'b0010, 1);
        checks++; if ({r, g, b} !== 3'b111) begin errors++; $display("FAIL release_run_rgb got %b want 111", {r, g, b}); end
        drive(4'b0000, 0);
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || {r, g, b} !== 3'b000) begin
            errors++; $display("FAIL release_idle got grant=%b busy=%b rgb=%b want 0000 0 000", grant, busy, {r, g, b});
        end
    endtask

    task automatic test_blink();
        int ticks;
        logic exp_g;
        do_reset();
        color = '0; blink = 4'b0001; color[2:0] = 3'b010;
        drive(4'b0001, 0);
        checks++; if (g !== 1'b1) begin errors++; $display("FAIL blink_start got %b want 1", g); end
        ticks = 0;
        for (int c = 0; c < 26; c++) begin
            drive(4'b0001, 1'(c % 2));
            if (c % 2 == 1) ticks++;
            exp_g = ((ticks / BT) % 2 == 0);
            checks++; if (g !== exp_g || r !== 1'b0 || b !== 1'b0) begin
                errors++; $display("FAIL blink_phase tick %0d got rgb=%b want g=%b", ticks, {r, g, b}, exp_g);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        color = '0; blink = '0; color[11:9] = 3'b100; color[5:3] = 3'b001;
        drive(4'b1000, 0);
        drive(4'b1000, 1);
        drive(4'b1000, 1);
        drive(4'b0010, 1);
        checks++; if (grant !== 4'b0010 || busy !== 1'b1 || {r, g, b} !== 3'b001) begin
            errors++; $display("FAIL b2b_grant got %b/%b/%b want 0010/1/001", grant, busy, {r, g, b});
        end
        drive(4'b0010, 1);
        drive(4'b0011, 0);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL b2b_tick_not_counted got %b want 0010", grant); end
        drive(4'b0011, 1);
        drive(4'b0011, 0);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL b2b_run_reached got %b want 0001", grant); end
    endtask

    task automatic test_async_reset();
        do_reset();
        color = '0; blink = '0; color[8:6] = 3'b111;
        drive(4'b0100, 0);
        drive(4'b0100, 1);
        drive(4'b0100, 1);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL areset_pre got %b want 0100", grant); end
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || {r, g, b} !== 3'b000) begin
            errors++; $display("FAIL areset_immediate got grant=%b busy=%b rgb=%b want 0000 0 000", grant, busy, {r, g, b});
        end
        model_reset();
        @(negedge clk);
        req = '0; tick = 0; rst_n = 1;
    endtask

    task automatic test_random();
        logic [N-1:0] rq;
        do_reset();
        rq = '0;
        for (int c = 0; c < 600; c++) begin
            color = 12'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rq = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom_range(0, 15));
                blink = N'($urandom_range(0, 15));
            end
            drive(rq, 1'($urandom_range(0, 1)));
            checks++; if (grant !== exp_grant()) begin errors++; $display("FAIL rand_grant cyc %0d got %b want %b", c, grant, exp_grant()); end
            checks++; if (busy !== (m_owner >= 0)) begin errors++; $display("FAIL rand_busy cyc %0d got %b want %b", c, busy, (m_owner >= 0)); end
            checks++; if ({r, g, b} !== exp_rgb()) begin errors++; $display("FAIL rand_rgb cyc %0d got %b want %b", c, {r, g, b}, exp_rgb()); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_ignore();
        test_release();
        test_blink();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rgb_arbiter.md
RGB_ARBITER -- requirements
Module: rgb_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter HOLD_TICKS, default 8: minimum dwell of a new grant, counted in tick strobes; legal range 1..255.
REQ-003 Parameter BLINK_TICKS, default 4: blink half-period, counted in tick strobes; legal range 1..255.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 tick  in  1  one-cycle timebase strobe, at most one per cycle.
REQ-007 req  in  NREQ  request vector; bit 0 is highest priority.
REQ-008 color  in  3*NREQ  per-requester colour; color[3i+2:3i] = {r,g,b} for requester i.
REQ-009 blink  in  NREQ  per-requester blink enable.
REQ-010 r, g, b  out  1 each  registered LED drive, active-high.
REQ-011 grant  out  NREQ  registered one-hot owner; all-zero when idle.
REQ-012 busy  out  1  registered; high in HOLD or RUN.

Function
REQ-013 The block SHALL implement three states: IDLE, HOLD, RUN.
REQ-014 IDLE: grant=0 and r=g=b=0; when any req bit is high, the block SHALL grant the lowest-index active requester and enter HOLD on the next edge.
REQ-015 At every grant, the block SHALL latch that requester's colour and blink bit, load hold_cnt=HOLD_TICKS, load blink_cnt=BLINK_TICKS, and set phase=1 (LED on).
REQ-016 A tick in the same cycle as a grant SHALL NOT decrement either counter.
REQ-017 HOLD: each tick SHALL decrement hold_cnt; the tick that takes hold_cnt from 1 to 0 SHALL move the state to RUN on that edge.
REQ-018 HOLD SHALL ignore the owner's req deassertion and all higher-priority requests; the latched colour stays displayed.
REQ-019 RUN: if a requester with index lower than the owner's is active, the block SHALL grant it and re-enter HOLD (preemption).
REQ-020 RUN: otherwise, if the owner's req is low, the block SHALL grant the lowest-index active requester and enter HOLD, or enter IDLE if none is active.
REQ-021 If the owner drops and a higher-priority requester rises in the same cycle, REQ-019 SHALL apply; no IDLE cycle occurs.
REQ-022 Blink: while busy and latched blink=1, each tick SHALL decrement blink_cnt; at 1->0 the block SHALL toggle phase and reload blink_cnt=BLINK_TICKS.
REQ-023 Outputs SHALL be {r,g,b} = latched colour AND (phase OR NOT latched blink), registered so they change on the same edge as grant.
REQ-024 Latency from req sampled high in IDLE to grant/LED valid SHALL be exactly 1 cycle.
REQ-025 Counter widths SHALL be $clog2(max+1) of their parameter; counters SHALL never wrap below 0.
REQ-026 Colour or blink input changes after grant SHALL have no effect until the next grant.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, grant=0, busy=0, r=g=b=0, hold_cnt=0, blink_cnt=0, phase=1, latched colour=0 and latched blink=0, including mid-HOLD or mid-RUN.
REQ-028 After rst_n rises, the first grant SHALL occur on the first edge where req!=0, and never earlier than one cycle after deassertion.

Verification
REQ-029 NREQ=4, HOLD_TICKS=2; req=0100, color[8:6]=101, blink=0 -> next cycle grant=0100, busy=1, rgb=101; RUN after 2 ticks.
REQ-030 Owner 2 in HOLD; req=0101 raised -> grant stays 0100 until 2nd tick; then on next cycle grant=0001.
REQ-031 Owner 1 in RUN; req goes 0010->0000 -> next cycle IDLE, grant=0000, rgb=000, busy=0.
REQ-032 BLINK_TICKS=3, owner blink=1, colour 010 -> g=1 for 3 ticks, 0 for 3 ticks, then repeats; r=b=0 throughout.
REQ-033 Owner 3 in RUN; req 1000->0010 on same cycle -> next cycle grant=0010 with no idle cycle; tick in the grant cycle is not counted.
REQ-034 rst_n pulsed low mid-RUN, asynchronous to clk -> grant, busy, r, g and b go to 0 immediately, before the next clk edge.
